// File: rtl/regfile_mp.sv
// regfile_mp: multi-port integer register file with busy scoreboard and post-reset clear sweep.
// Optional same-cycle write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_mp #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int NRD  = 2,
    parameter int NWR  = 1,
    parameter int AW   = $clog2(NREG)
) (
    input  logic                clk,
    input  logic                rst,
    output logic                ready,
    input  logic [NRD-1:0]      rden,
    input  logic [NRD*AW-1:0]   raddr,
    output logic [NRD*XLEN-1:0] rdata,
    output logic [NRD-1:0]      rbusy,
    input  logic [NWR-1:0]      wren,
    input  logic [NWR*AW-1:0]   waddr,
    input  logic [NWR*XLEN-1:0] wdata,
    input  logic                rsv_en,
    input  logic [AW-1:0]       rsv_addr
);
    typedef enum logic {CLEAR, RUN} state_e;

    state_e          state_q;
    logic [AW-1:0]   idx_q;
    logic            ready_q;
    logic [XLEN-1:0] mem_q [NREG];
    logic [NREG-1:0] busy_q, busy_d;
    logic            run;

    assign run   = state_q == RUN;
    assign ready = ready_q;

    // Sweep sequencer and scoreboard; reset aborts everything and restarts the sweep at entry 1
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= CLEAR;
            idx_q   <= AW'(1);
            ready_q <= 1'b0;
            busy_q  <= '0;
        end else begin
            busy_q <= busy_d;
            if (state_q == CLEAR) begin
                idx_q <= idx_q + AW'(1);
                if (idx_q == AW'(NREG - 1)) begin
                    state_q <= RUN;
                    ready_q <= 1'b1;
                end
            end
        end
    end

    // Storage has no reset so it maps to RAM; the sweep zeroes it, later ports override earlier ones
    always_ff @(posedge clk) begin
        if (state_q == CLEAR)
            mem_q[idx_q] <= '0;
        else
            for (int j = 0; j < NWR; j++)
                if (wren[j] && waddr[j*AW +: AW] != '0)
                    mem_q[waddr[j*AW +: AW]] <= wdata[j*XLEN +: XLEN];
    end

    // Writes retire a pending producer; a same-cycle reserve re-arms it for the new producer
    always_comb begin
        busy_d = busy_q;
        if (run) begin
            for (int j = 0; j < NWR; j++)
                if (wren[j])
                    busy_d[waddr[j*AW +: AW]] = 1'b0;
            if (rsv_en)
                busy_d[rsv_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Combinational read ports; register 0 and disabled ports read as zero and never busy
    always_comb begin
        rdata = '0;
        rbusy = '0;
        for (int i = 0; i < NRD; i++) begin
            if (run && rden[i] && raddr[i*AW +: AW] != '0) begin
                rdata[i*XLEN +: XLEN] = mem_q[raddr[i*AW +: AW]];
                rbusy[i]              = busy_q[raddr[i*AW +: AW]];
`ifdef REGFILE_BYPASS_EN
                for (int j = 0; j < NWR; j++)
                    if (wren[j] && waddr[j*AW +: AW] == raddr[i*AW +: AW]) begin
                        rdata[i*XLEN +: XLEN] = wdata[j*XLEN +: XLEN];
                        rbusy[i]              = rsv_en && rsv_addr == raddr[i*AW +: AW];
                    end
`else
`endif
            end
        end
    end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: randomized and directed check of regfile_mp against an array-based reference model
module tb_regfile_mp;
    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int NRD  = 2;
    localparam int NWR  = 2;
    localparam int AW   = 5;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                ready;
    logic [NRD-1:0]      rden = '0;
    logic [NRD*AW-1:0]   raddr = '0;
    logic [NRD*XLEN-1:0] rdata;
    logic [NRD-1:0]      rbusy;
    logic [NWR-1:0]      wren = '0;
    logic [NWR*AW-1:0]   waddr = '0;
    logic [NWR*XLEN-1:0] wdata = '0;
    logic                rsv_en = 1'b0;
    logic [AW-1:0]       rsv_addr = '0;

    int vecs = 0;
    int errs = 0;

    logic [XLEN-1:0] m_mem [NREG];
    bit              m_busy [NREG];
    bit              m_ready = 0;

    regfile_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR)) dut (
        .clk(clk), .rst(rst), .ready(ready),
        .rden(rden), .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
        .wren(wren), .waddr(waddr), .wdata(wdata),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Expected {busy, data} for read port i given the current inputs and model state
    function automatic logic [XLEN:0] exp_read(input int i);
        int a;
        logic [XLEN-1:0] d;
        logic b;
        a = int'(raddr[i*AW +: AW]);
        if (!m_ready || !rden[i] || a == 0) return '0;
        d = m_mem[a];
        b = m_busy[a];
`ifdef REGFILE_BYPASS_EN
        for (int j = 0; j < NWR; j++)
            if (wren[j] && int'(waddr[j*AW +: AW]) == a) begin
                d = wdata[j*XLEN +: XLEN];
                b = rsv_en && int'(rsv_addr) == a;
            end
`endif
        return {b, d};
    endfunction

    task automatic check_reads(input string tag);
        logic [XLEN:0] e;
        for (int i = 0; i < NRD; i++) begin
            e = exp_read(i);
            chk({tag, "_data"}, rdata[i*XLEN +: XLEN], e[XLEN-1:0]);
            chk({tag, "_busy"}, XLEN'(rbusy[i]), XLEN'(e[XLEN]));
        end
    endtask

    task automatic idle();
        rden = '0; wren = '0; rsv_en = 1'b0;
    endtask

    task automatic wr(input int j, input int a, input logic [XLEN-1:0] d);
        wren[j] = 1'b1;
        waddr[j*AW +: AW] = AW'(a);
        wdata[j*XLEN +: XLEN] = d;
    endtask

    task automatic rd(input int i, input int a);
        rden[i] = 1'b1;
        raddr[i*AW +: AW] = AW'(a);
    endtask

    task automatic rsv(input int a);
        rsv_en = 1'b1;
        rsv_addr = AW'(a);
    endtask

    // Check reads with current inputs, then advance one edge and update the model
    task automatic cycle(input string tag);
        int a;
        #1;
        check_reads(tag);
        @(posedge clk);
        if (m_ready) begin
            for (int j = 0; j < NWR; j++) begin
                a = int'(waddr[j*AW +: AW]);
                if (wren[j] && a != 0) begin
                    m_mem[a] = wdata[j*XLEN +: XLEN];
                    m_busy[a] = 0;
                end
            end
            if (rsv_en && rsv_addr != '0) m_busy[rsv_addr] = 1;
        end
        #1;
    endtask

    // Release reset and count edges until ready, driving junk requests that must be ignored
    task automatic sweep();
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < NREG - 1; k++) begin
            rden = NRD'($urandom); raddr = NRD*AW'($urandom);
            wren = NWR'($urandom); waddr = NWR*AW'($urandom); wdata = {$urandom, $urandom};
            rsv_en = 1'b1; rsv_addr = AW'($urandom);
            #1;
            chk("sweep_ready_low", XLEN'(ready), '0);
            check_reads("sweep_read");
            @(posedge clk);
            #1;
        end
        chk("sweep_ready_high", XLEN'(ready), 1);
        m_ready = 1;
        for (int a = 0; a < NREG; a++) begin m_mem[a] = '0; m_busy[a] = 0; end
        idle();
        for (int a = 1; a < NREG; a += 2) begin
            rd(0, a); rd(1, a + 1 < NREG ? a + 1 : 1);
            cycle("post_sweep_read");
            chk("post_sweep_zero", rdata[0 +: XLEN], '0);
        end
        idle();
    endtask

    initial begin
        for (int a = 0; a < NREG; a++) begin m_mem[a] = '0; m_busy[a] = 0; end
        #12;
        rd(0, 5); rd(1, 9);
        #1;
        chk("reset_ready", XLEN'(ready), '0);
        chk("reset_rdata", rdata[0 +: XLEN], '0);
        chk("reset_rbusy", XLEN'(rbusy), '0);
        idle();
        sweep();

        wr(0, 5, 32'hDEADBEEF); wr(1, 9, 32'h12345678);
        cycle("dual_write");
        idle(); rd(0, 5); rd(1, 9);
        #1;
        chk("r5_value", rdata[0 +: XLEN], 32'hDEADBEEF);
        chk("r9_value", rdata[XLEN +: XLEN], 32'h12345678);
        cycle("dual_read");
        idle(); wr(0, 0, 32'hFFFFFFFF);
        cycle("write_r0");
        idle(); rd(0, 0);
        #1;
        chk("r0_zero", rdata[0 +: XLEN], '0);
        cycle("read_r0");

        idle(); wr(0, 7, 32'h1); wr(1, 7, 32'h2);
        cycle("collision_write");
        idle(); rd(0, 7);
        #1;
        chk("collision_r7", rdata[0 +: XLEN], 32'h2);
        cycle("collision_read");

        idle(); rsv(3);
        cycle("reserve_r3");
        idle(); rd(0, 3);
        #1;
        chk("r3_busy_after_rsv", XLEN'(rbusy[0]), 1);
        wr(0, 3, 32'hCAFE0003);
        cycle("write_r3");
        idle(); rd(0, 3);
        #1;
        chk("r3_busy_cleared", XLEN'(rbusy[0]), '0);
        rsv(3); wr(1, 3, 32'h0BADF00D);
        cycle("rsv_and_write_r3");
        idle(); rd(0, 3);
        #1;
        chk("r3_busy_kept", XLEN'(rbusy[0]), 1);
        chk("r3_data_kept", rdata[0 +: XLEN], 32'h0BADF00D);
        cycle("rsv_write_read");

        idle(); rd(0, 4); wr(0, 4, 32'hA5A5A5A5);
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("bypass_same_cycle", rdata[0 +: XLEN], 32'hA5A5A5A5);
`else
        chk("bypass_same_cycle", rdata[0 +: XLEN], '0);
`endif
        cycle("bypass_write");
        idle(); rd(0, 4);
        #1;
        chk("bypass_next_cycle", rdata[0 +: XLEN], 32'hA5A5A5A5);
        cycle("bypass_read");

        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NRD; i++) begin
                rden[i] = ($urandom % 4) != 0;
                raddr[i*AW +: AW] = AW'(($urandom % 4 == 0) ? $urandom % NREG : $urandom % 8);
            end
            for (int j = 0; j < NWR; j++) begin
                wren[j] = $urandom % 2 == 0;
                waddr[j*AW +: AW] = AW'(($urandom % 4 == 0) ? $urandom % NREG : $urandom % 8);
                wdata[j*XLEN +: XLEN] = $urandom;
            end
            rsv_en = $urandom % 3 == 0;
            rsv_addr = AW'($urandom % 8);
            cycle("random");
        end

        idle(); rsv(3);
        cycle("pre_reset_rsv");
        idle(); rd(0, 3);
        #1;
        chk("pre_reset_busy", XLEN'(rbusy[0]), 1);
        #2;
        rst = 1'b0;
        m_ready = 0;
        for (int a = 0; a < NREG; a++) m_busy[a] = 0;
        #1;
        chk("midreset_ready", XLEN'(ready), '0);
        chk("midreset_rbusy", XLEN'(rbusy[0]), '0);
        chk("midreset_rdata", rdata[0 +: XLEN], '0);
        @(posedge clk);
        #1;
        sweep();

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port integer register file that succeeds the single-write/dual-read file in the pipeline's decode/writeback path. It provides NRD read ports and NWR write ports, with a per-register busy scoreboard for hazard detection. After reset it runs a sweep state machine that clears every entry, so the array maps onto RAM-style storage. Register 0 is hardwired to zero and is never busy.

## Interface
Parameters:
- XLEN, 32, data width in bits
- NREG, 32, number of architectural registers; power of two, at least 4
- NRD, 2, number of read ports
- NWR, 1, number of write ports, 1 to 4
- AW, $clog2(NREG), address width (derived; do not override)

Ports (clock and reset first):
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  reset; asynchronous, active-low
- ready  out  1  high once the post-reset clear sweep has completed
- rden  in  NRD  per-port read enable
- raddr  in  NRD*AW  read addresses; port i occupies bits [i*AW +: AW]
- rdata  out  NRD*XLEN  read data per port
- rbusy  out  NRD  high when the addressed register has a pending write
- wren  in  NWR  per-port write enable
- waddr  in  NWR*AW  write addresses
- wdata  in  NWR*XLEN  write data
- rsv_en  in  1  reserve: mark rsv_addr as busy
- rsv_addr  in  AW  register to reserve

## Operation
- The state machine has two states: CLEAR and RUN.
  - rst low: state=CLEAR, sweep index=1, ready=0, all busy bits=0.
- CLEAR:
  - Each cycle writes 0 to entry[index] and increments index.
  - When index=NREG-1 is written, the machine moves to RUN on the next edge, and ready=1 from that edge on.
  - Duration is NREG-1 cycles after rst rises.
  - wren and rsv_en are ignored.
  - rdata=0 and rbusy=0 on all ports.
- RUN, reads (combinational):
  - rden[i]=0 or raddr=0: rdata[i]=0 and rbusy[i]=0.
  - Otherwise rdata[i]=entry[raddr], and rbusy[i]=busy[raddr].
- RUN, writes:
  - wren[j]=1 and waddr[j]!=0: entry[waddr[j]] takes wdata[j] and busy[waddr[j]] is cleared.
  - Writes to address 0 are dropped.
- Write-port collision: if several write ports target the same address in one cycle, the highest port index wins. All of those ports still count as clearing busy.
- Reserve: rsv_en=1 and rsv_addr!=0 sets busy[rsv_addr].
  - If a write to the same address occurs in the same cycle, the reserve wins and busy stays 1 (a new producer has been issued). The write data is still stored.
- rst going low mid-operation aborts everything immediately:
  - ready=0 and all busy bits=0.
  - The sweep restarts from index 1 after rst rises.
  - Entry contents are not preserved.

## Timing
- Reset values: ready=0, rdata=0, rbusy=0, all busy bits=0.
- Read latency is 0 cycles; rdata and rbusy follow raddr combinationally.
- A write is visible to reads the cycle after the edge that commits it (unless bypass is enabled).
- A reserve is visible on rbusy the cycle after the edge.
- ready rises exactly NREG-1 rising edges after rst deasserts. Example: NREG=32 gives 31 edges.
- There is no backpressure: all write and reserve requests in RUN complete in one cycle.

## Configuration
- REGFILE_BYPASS_EN defined:
  - In RUN, a same-cycle write to the register being read is forwarded, so rdata[i] equals the winning wdata[j] for that address.
  - rbusy[i] is then 0, unless rsv_en targets the same address in that cycle.
  - Address 0 is never forwarded.
- Undefined: there is no forwarding. Reads return the array contents only, and rbusy reflects the stored busy bit.

## Test plan
- Reset sweep, NREG=32: release rst and count edges -> ready=0 for 31 edges, then 1; every read of addresses 1..31 returns 0.
- Basic write/read, NWR=2: port0 writes r5=0xDEADBEEF and port1 writes r9=0x12345678 in the same cycle -> next cycle, reads return both values; a write to r0 still reads 0.
- Collision: port0 writes r7=0x1 and port1 writes r7=0x2 in one cycle -> r7 reads 0x2.
- Scoreboard: reserve r3 -> rbusy=1 next cycle; write r3 -> rbusy=0 next cycle; a reserve and a write to r3 in the same cycle -> rbusy stays 1 and the data reads back as written.
- Bypass, with and without REGFILE_BYPASS_EN: write r4=0xA5A5A5A5 while reading r4 in the same cycle -> with the macro, rdata=0xA5A5A5A5 that cycle; without it, the old value that cycle and the new value next cycle.
- Mid-operation reset: assert rst while r3 is busy -> ready=0 and rbusy=0 immediately; after release, the sweep repeats and all entries read 0.
